alu_ctrl_mdu: RTL

ALU_CTRL_MDU -- requirements
Module: alu_ctrl_mdu

---
 rtl/alu_pkg.sv | 63 ++++++
 rtl/mdu_iter.sv | 107 ++++++++++
 rtl/alu_ctrl_mdu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings, funct codes and the multiply/divide FSM states.
// The DIV state exists only when ALU_CTRL_MDU_DIV_EN is defined.
package alu_pkg;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ANDI  = 2'b11;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NONE = 4'b1111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef ALU_CTRL_MDU_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_DONE = 2'd3
  } md_state_t;

  // Multiply/divide functs fall through to OP_NONE: they never use the ALU.
  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    logic [3:0] op;
    op = OP_NONE;
    case (aluop)
      ALU_ADD:  op = OP_ADD;
      ALU_SUB:  op = OP_SUB;
      ALU_ANDI: op = OP_AND;
      default: begin
        case (funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_SLT:  op = OP_SLT;
          FN_NOR:  op = OP_NOR;
          default: op = OP_NONE;
        endcase
      end
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative one-bit-per-step multiply (shift-add) and, with ALU_CTRL_MDU_DIV_EN,
// restoring divide datapath working on magnitudes; signs are applied on the result.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
`ifdef ALU_CTRL_MDU_DIV_EN
  input  logic             div_sel,
`endif
  input  logic             signed_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b_in;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_main;

  assign a_neg    = signed_sel & op_a[WIDTH-1];
  assign b_neg    = signed_sel & op_b[WIDTH-1];
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b_in = b_neg ? -op_b : op_b;

  // Multiply keeps {partial, multiplier} in acc and shifts right each step.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    mul_next = {sum, acc[WIDTH-1:1]};
  end

  assign prod_signed = neg_main ? -acc : acc;

`ifdef ALU_CTRL_MDU_DIV_EN
  logic             div_mode;
  logic             neg_rem;
  logic             b_zero;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;

  // Divide keeps {remainder, dividend/quotient} in acc and shifts left each step.
  always_comb begin
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    ge       = shifted >= {1'b0, mag_b};
    rem_next = ge ? (shifted[WIDTH-1:0] - mag_b) : shifted[WIDTH-1:0];
    acc_next = div_mode ? {rem_next, acc[WIDTH-2:0], ge} : mul_next;
  end

  assign q_mag = acc[WIDTH-1:0];
  assign r_mag = acc[2*WIDTH-1:WIDTH];

  always_comb begin
    res_hi = prod_signed[2*WIDTH-1:WIDTH];
    res_lo = prod_signed[WIDTH-1:0];
    if (div_mode) begin
      res_hi = neg_rem ? -r_mag : r_mag;
      res_lo = b_zero ? '1 : (neg_main ? -q_mag : q_mag);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_mode <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
    end else if (start) begin
      div_mode <= div_sel;
      neg_rem  <= a_neg;
      b_zero   <= (op_b == '0);
    end
  end
`else
  assign acc_next = mul_next;
  assign res_hi   = prod_signed[2*WIDTH-1:WIDTH];
  assign res_lo   = prod_signed[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mag_b    <= '0;
      neg_main <= 1'b0;
    end else if (start) begin
      acc      <= {{WIDTH{1'b0}}, mag_a};
      mag_b    <= mag_b_in;
      neg_main <= a_neg ^ b_neg;
    end else if (step) begin
      acc      <= acc_next;
    end
  end

endmodule

// File: rtl/alu_ctrl_mdu.sv
// ALU control decoder plus HI/LO multiply/divide sequencer with pipeline stall.
// Divide support is built only when ALU_CTRL_MDU_DIV_EN is defined.
module alu_ctrl_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUop,
  input  logic [31:0]      instruction,
  input  logic             issue,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       Operation,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             md_busy,
  output logic             md_done,
  output logic             stall
);

  localparam int               CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       funct;
  logic             r_type;
  logic             is_md;
  logic             is_mf;
  logic             start;
  logic             step;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             unused_instr_bits;

  assign funct             = instruction[5:0];
  assign unused_instr_bits = ^instruction[31:6];
  assign r_type            = (ALUop == ALU_RTYPE);
  assign Operation         = alu_decode(ALUop, funct);

`ifdef ALU_CTRL_MDU_DIV_EN
  logic is_div;
  assign is_div = (funct == FN_DIV) || (funct == FN_DIVU);
  assign is_md  = r_type && ((funct == FN_MULT) || (funct == FN_MULTU) || is_div);
`else
  assign is_md  = r_type && ((funct == FN_MULT) || (funct == FN_MULTU));
`endif
  assign is_mf  = r_type && ((funct == FN_MFHI) || (funct == FN_MFLO));

  // Any HI/LO user must wait until the result has actually landed in hi/lo.
  assign stall = issue && (is_md || is_mf) && (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    md_busy    = 1'b0;
    md_done    = 1'b0;
    start      = 1'b0;
    step       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue && is_md) begin
          start = 1'b1;
`ifdef ALU_CTRL_MDU_DIV_EN
          state_next = is_div ? ST_DIV : ST_MUL;
`else
          state_next = ST_MUL;
`endif
        end
      end
      ST_MUL: begin
        md_busy = 1'b1;
        step    = 1'b1;
        if (cnt == LAST) state_next = ST_DONE;
      end
`ifdef ALU_CTRL_MDU_DIV_EN
      ST_DIV: begin
        md_busy = 1'b1;
        step    = 1'b1;
        if (cnt == LAST) state_next = ST_DONE;
      end
`endif
      ST_DONE: begin
        md_done    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (start) cnt <= '0;
    else if (step)  cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_DONE) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .step       (step),
`ifdef ALU_CTRL_MDU_DIV_EN
    .div_sel    (funct[1]),
`endif
    .signed_sel (~funct[0]),
    .op_a       (rs_val),
    .op_b       (rt_val),
    .res_hi     (res_hi),
    .res_lo     (res_lo)
  );

endmodule
